// File: rtl/player_shot_ctrl.sv
// rtl/player_shot_ctrl.sv - player projectile: launch on fire edge, rise per frame, retire on hit/top, paint pixels
module player_shot_ctrl #(
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 8,
  parameter int X_OFFSET = 11,
  parameter int SHOT_W   = 2,
  parameter int SHOT_H   = 6,
  parameter int PARK     = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       hit,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic [9:0] shot_x,
  output logic [9:0] shot_y,
  output logic       active,
  output logic [7:0] shot_count,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLY  = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  localparam logic [9:0]  PARK_V   = 10'(PARK);
  localparam logic [9:0]  SPEED_V  = 10'(SPEED);
  localparam logic [9:0]  SHOT_H_V = 10'(SHOT_H);
  localparam logic [10:0] SHOT_H_W = 11'(SHOT_H);
  localparam logic [10:0] SHOT_W_W = 11'(SHOT_W);
  localparam logic [10:0] X_OFF_W  = 11'(X_OFFSET);
  localparam logic [10:0] X_MAX_W  = 11'd639;
  localparam logic [7:0]  COOL_V   = 8'(COOLDOWN);

  logic [1:0] state_q, state_d;
  logic [7:0] cool_q, cool_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] count_q, count_d;
  logic       fire_prev_q;

  logic        fire_edge;
  logic [10:0] launch_x;
  logic [9:0]  sat_x;
  logic [9:0]  launch_y;

  assign fire_edge = fire & ~fire_prev_q;
  assign launch_x  = {1'b0, player_x} + X_OFF_W;
  assign sat_x     = (launch_x > X_MAX_W) ? 10'd639 : launch_x[9:0];
  assign launch_y  = (player_y < SHOT_H_V) ? 10'd0 : player_y - SHOT_H_V;

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    x_d     = x_q;
    y_d     = y_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (fire_edge) begin
          state_d = S_FLY;
          x_d     = sat_x;
          y_d     = launch_y;
          count_d = count_q + 8'd1;
        end
      end
      S_FLY: begin
        // A hit wins over a frame_tick in the same cycle; either retirement parks the shot.
        if (hit || (frame_tick && (y_q < SPEED_V))) begin
          state_d = S_COOL;
          cool_d  = 8'd0;
          x_d     = PARK_V;
          y_d     = PARK_V;
        end else if (frame_tick) begin
          y_d = y_q - SPEED_V;
        end
      end
      S_COOL: begin
        if (cool_q == COOL_V) begin
          state_d = S_IDLE;
        end else if (frame_tick) begin
          cool_d = cool_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        x_d     = PARK_V;
        y_d     = PARK_V;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cool_q      <= 8'd0;
      x_q         <= PARK_V;
      y_q         <= PARK_V;
      count_q     <= 8'd0;
      fire_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cool_q      <= cool_d;
      x_q         <= x_d;
      y_q         <= y_d;
      count_q     <= count_d;
      fire_prev_q <= fire;
    end
  end

  assign shot_x     = x_q;
  assign shot_y     = y_q;
  assign active     = (state_q == S_FLY);
  assign shot_count = count_q;

  // 11-bit bounds so a shot near column/row 1023 cannot wrap into the visible area.
  logic [10:0] hx, vy, sx, sy;
  logic        in_shot;
  assign hx      = {1'b0, h_counter};
  assign vy      = {1'b0, v_counter};
  assign sx      = {1'b0, x_q};
  assign sy      = {1'b0, y_q};
  assign in_shot = active && (hx >= sx) && (hx < sx + SHOT_W_W) &&
                   (vy >= sy) && (vy < sy + SHOT_H_W);

  assign R = in_shot ? 8'hFF : 8'h00;
  assign G = in_shot ? 8'hFF : 8'h00;
  assign B = in_shot ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_player_shot_ctrl.sv
// tb/tb_player_shot_ctrl.sv - directed and randomized checks of player_shot_ctrl against a behavioural model
module tb_player_shot_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] player_x = 10'd0;
  logic [9:0] player_y = 10'd0;
  logic [9:0] h_counter = 10'd0;
  logic [9:0] v_counter = 10'd0;
  logic [9:0] shot_x, shot_y;
  logic       active;
  logic [7:0] shot_count, R, G, B;

  int total = 0;
  int bad = 0;

  player_shot_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
    .player_x(player_x), .player_y(player_y), .hit(hit),
    .h_counter(h_counter), .v_counter(v_counter),
    .shot_x(shot_x), .shot_y(shot_y), .active(active), .shot_count(shot_count),
    .R(R), .G(G), .B(B)
  );

  always #5 clk = ~clk;

  // Behavioural model: a shot is either flying, cooling down (frames left), or ready.
  bit m_fire_prev = 1'b1;
  bit m_fly = 1'b0;
  bit m_cool = 1'b0;
  int m_left = 0;
  int m_x = 0;
  int m_y = 0;
  int m_cnt = 0;

  task automatic model_step();
    bit pressed;
    if (reset) begin
      m_fire_prev = 1'b1; m_fly = 1'b0; m_cool = 1'b0; m_left = 0; m_cnt = 0;
    end else begin
      pressed = fire && !m_fire_prev;
      m_fire_prev = fire;
      if (m_fly) begin
        if (hit || (frame_tick && m_y < 4)) begin
          m_fly = 1'b0; m_cool = 1'b1; m_left = 8;
        end else if (frame_tick) begin
          m_y = m_y - 4;
        end
      end else if (m_cool) begin
        if (m_left == 0) m_cool = 1'b0;
        else if (frame_tick) m_left = m_left - 1;
      end else if (pressed) begin
        m_fly = 1'b1;
        m_x = (int'(player_x) + 11 > 639) ? 639 : int'(player_x) + 11;
        m_y = (int'(player_y) < 6) ? 0 : int'(player_y) - 6;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  function automatic bit exp_pix();
    int h, v;
    h = int'(h_counter);
    v = int'(v_counter);
    return m_fly && h >= m_x && h < m_x + 2 && v >= m_y && v < m_y + 6;
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0; cyc();
  endtask

  task automatic press();
    fire = 1'b1; cyc();
    fire = 1'b0;
  endtask

  task automatic drain();
    repeat (8) tick();
    cyc(); cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; fire = 1'b1; player_x = 10'd300; player_y = 10'd440;
    cyc(); cyc();
    reset = 1'b0;
    h_counter = 10'd1023; v_counter = 10'd1023; #1;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%0d want=0", active); end
    total++; if (shot_x !== 10'd1023) begin bad++; $display("FAIL reset_x got=%0d want=1023", shot_x); end
    total++; if (shot_y !== 10'd1023) begin bad++; $display("FAIL reset_y got=%0d want=1023", shot_y); end
    total++; if (shot_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", shot_count); end
    total++; if ({R, G, B} !== 24'h0) begin bad++; $display("FAIL reset_park_pixel got=%h want=000000", {R, G, B}); end
    cyc(); cyc(); cyc();
    total++; if (active !== 1'b0) begin bad++; $display("FAIL held_fire_no_launch got=%0d want=0", active); end
    fire = 1'b0; cyc();
    press();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL launch_active got=%0d want=1", active); end
    total++; if (shot_x !== 10'd311) begin bad++; $display("FAIL launch_x got=%0d want=311", shot_x); end
    total++; if (shot_y !== 10'd434) begin bad++; $display("FAIL launch_y got=%0d want=434", shot_y); end
    total++; if (shot_count !== 8'd1) begin bad++; $display("FAIL launch_count got=%0d want=1", shot_count); end
  endtask

  task automatic test_flight();
    player_x = 10'd100;
    repeat (10) tick();
    total++; if (shot_y !== 10'd394) begin bad++; $display("FAIL flight_y got=%0d want=394", shot_y); end
    total++; if (shot_x !== 10'd311) begin bad++; $display("FAIL flight_x got=%0d want=311", shot_x); end
    h_counter = 10'd312; v_counter = 10'd399; #1;
    total++; if ({R, G, B} !== 24'hFFFFFF) begin bad++; $display("FAIL pix_inside got=%h want=ffffff", {R, G, B}); end
    h_counter = 10'd313; #1;
    total++; if ({R, G, B} !== 24'h0) begin bad++; $display("FAIL pix_right got=%h want=000000", {R, G, B}); end
    h_counter = 10'd312; v_counter = 10'd400; #1;
    total++; if ({R, G, B} !== 24'h0) begin bad++; $display("FAIL pix_below got=%h want=000000", {R, G, B}); end
  endtask

  task automatic test_top_exit();
    repeat (98) tick();
    total++; if (shot_y !== 10'd2) begin bad++; $display("FAIL top_y got=%0d want=2", shot_y); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL top_active got=%0d want=1", active); end
    tick();
    total++; if (active !== 1'b0) begin bad++; $display("FAIL exit_active got=%0d want=0", active); end
    total++; if ({shot_x, shot_y} !== {10'd1023, 10'd1023}) begin
      bad++; $display("FAIL exit_park got=%0d,%0d want=1023,1023", shot_x, shot_y);
    end
    for (int i = 0; i < 8; i++) begin
      press(); cyc();
      h_counter = 10'd311; v_counter = 10'd2; #1;
      total++; if (active !== 1'b0 || {R, G, B} !== 24'h0) begin
        bad++; $display("FAIL cooldown_ignore i=%0d got=%0d/%h want=0/000000", i, active, {R, G, B});
      end
      tick();
    end
    cyc();
    press();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL relaunch_active got=%0d want=1", active); end
    total++; if (shot_count !== 8'd2) begin bad++; $display("FAIL relaunch_count got=%0d want=2", shot_count); end
    total++; if (shot_x !== 10'd111) begin bad++; $display("FAIL relaunch_x got=%0d want=111", shot_x); end
  endtask

  task automatic test_hit_tick();
    hit = 1'b1; frame_tick = 1'b1; cyc();
    hit = 1'b0; frame_tick = 1'b0;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL hit_active got=%0d want=0", active); end
    total++; if ({shot_x, shot_y} !== {10'd1023, 10'd1023}) begin
      bad++; $display("FAIL hit_park got=%0d,%0d want=1023,1023", shot_x, shot_y);
    end
    cyc(); press();
    total++; if (active !== 1'b0) begin bad++; $display("FAIL hit_cool_ignore got=%0d want=0", active); end
    drain();
  endtask

  task automatic test_clamp();
    player_x = 10'd635; player_y = 10'd3;
    press();
    total++; if (shot_x !== 10'd639) begin bad++; $display("FAIL clamp_x got=%0d want=639", shot_x); end
    total++; if (shot_y !== 10'd0) begin bad++; $display("FAIL clamp_y got=%0d want=0", shot_y); end
    tick();
    total++; if (active !== 1'b0) begin bad++; $display("FAIL clamp_exit got=%0d want=0", active); end
    drain();
  endtask

  task automatic test_reset_midflight();
    player_x = 10'd300; player_y = 10'd440;
    press();
    reset = 1'b1; cyc(); reset = 0;
    total++; if (active !== 1'b0 || shot_count !== 8'd0 || shot_x !== 10'd1023 || shot_y !== 10'd1023) begin
      bad++; $display("FAIL midflight_reset got=%0d/%0d/%0d/%0d want=0/0/1023/1023", active, shot_count, shot_x, shot_y);
    end
    cyc();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 257; i++) begin
      press();
      hit = 1'b1; cyc(); hit = 1'b0;
      drain();
    end
    total++; if (shot_count !== 8'd1) begin bad++; $display("FAIL count_wrap got=%0d want=1", shot_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom % 400) == 0;
      fire       = ($urandom % 4) == 0;
      frame_tick = ($urandom % 3) == 0;
      hit        = ($urandom % 10) == 0;
      player_x   = 10'($urandom);
      player_y   = 10'($urandom);
      cyc();
      h_counter = 10'(m_x + int'($urandom_range(0, 3)) - 1);
      v_counter = 10'(m_y + int'($urandom_range(0, 7)) - 1);
      #1;
      total++; if (active !== m_fly) begin bad++; $display("FAIL rnd_active i=%0d got=%0d want=%0d", i, active, m_fly); end
      total++; if (shot_x !== (m_fly ? 10'(m_x) : 10'd1023) || shot_y !== (m_fly ? 10'(m_y) : 10'd1023)) begin
        bad++; $display("FAIL rnd_pos i=%0d got=%0d,%0d want_fly=%0d model=%0d,%0d", i, shot_x, shot_y, m_fly, m_x, m_y);
      end
      total++; if (shot_count !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_count i=%0d got=%0d want=%0d", i, shot_count, m_cnt); end
      total++; if ({R, G, B} !== (exp_pix() ? 24'hFFFFFF : 24'h0)) begin
        bad++; $display("FAIL rnd_pixel i=%0d got=%h want=%0d h=%0d v=%0d", i, {R, G, B}, exp_pix(), h_counter, v_counter);
      end
    end
    reset = 1'b0; fire = 1'b0; hit = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_flight();
    test_top_exit();
    test_hit_tick();
    test_clamp();
    test_reset_midflight();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
